// File: rtl/snn_pkg.sv
// Shared packet layout, type codes and controller state for the SNN input memory.
// The optional end-of-timestep marker is selected in the top with SNN_MEM_TS_MARKER_EN.
package snn_pkg;

    localparam logic [2:0] DST_BCAST_X = 3'h7;
    localparam logic [4:0] DST_BCAST_Y = 5'h1F;
    localparam int         PKT_IDX_W   = 5;
    localparam int         PKT_DATA_W  = 17;

    typedef enum logic [1:0] {
        PKT_FILTER   = 2'b00,
        PKT_IFMAP_LO = 2'b01,
        PKT_IFMAP_HI = 2'b10,
        PKT_TS_END   = 2'b11
    } pkt_type_e;

    // Field order matches the wire layout MSB first: dst_x, dst_y, type, idx, data.
    typedef struct packed {
        logic [2:0]            dst_x;
        logic [4:0]            dst_y;
        pkt_type_e             ptype;
        logic [PKT_IDX_W-1:0]  idx;
        logic [PKT_DATA_W-1:0] data;
    } pkt_t;

    typedef enum logic {
        SRC_LOAD   = 1'b0,
        SRC_STREAM = 1'b1
    } src_state_e;

    function automatic pkt_t make_pkt(input logic [2:0] dst_x, input logic [4:0] dst_y,
                                      input pkt_type_e ptype, input logic [PKT_IDX_W-1:0] idx,
                                      input logic [PKT_DATA_W-1:0] data);
        pkt_t p;
        p.dst_x = dst_x;
        p.dst_y = dst_y;
        p.ptype = ptype;
        p.idx   = idx;
        p.data  = data;
        return p;
    endfunction

endpackage

// File: rtl/snn_pkt_src.sv
// Generic LOAD/STREAM controller: counts N in-range writes, then walks packet indices
// 0..NPKT-1 under valid/ready before returning to LOAD.
module snn_pkt_src
    import snn_pkg::*;
#(
    parameter int N    = 25,
    parameter int NPKT = 25,
    parameter int CW   = $clog2(N + 1),
    parameter int IW   = $clog2(NPKT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wr_valid,
    input  logic          i_wr_in_range,
    output logic          o_wr_ready,
    output logic          o_wr_store,
    input  logic          i_pkt_ready,
    output logic          o_pkt_valid,
    output logic [IW-1:0] o_idx
);

    src_state_e    r_state;
    src_state_e    w_state_next;
    logic [CW-1:0] r_cnt;
    logic [IW-1:0] r_idx;
    logic          w_cnt_last;
    logic          w_idx_last;

    assign w_cnt_last = (r_cnt == CW'(N - 1));
    assign w_idx_last = (r_idx == IW'(NPKT - 1));
    assign o_idx      = r_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SRC_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SRC_LOAD:   if (o_wr_store && w_cnt_last) w_state_next = SRC_STREAM;
            SRC_STREAM: if (i_pkt_ready && w_idx_last) w_state_next = SRC_LOAD;
            default:    w_state_next = SRC_LOAD;
        endcase
    end

    // Valid is a decode of the state register, so it drops as soon as rst resets the state.
    always_comb begin
        o_wr_ready  = (r_state == SRC_LOAD);
        o_pkt_valid = (r_state == SRC_STREAM);
        o_wr_store  = o_wr_ready & i_wr_valid & i_wr_in_range;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (r_state == SRC_LOAD) begin
            r_idx <= '0;
            if (o_wr_store) r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
        end else if (i_pkt_ready) begin
            r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
        end
    end

endmodule

// File: rtl/snn_input_mem.sv
// Filter and ifmap source memories streamed as NoC packets into the top-left router.
// Define SNN_MEM_TS_MARKER_EN to append an end-of-timestep packet after each ifmap stream.
module snn_input_mem
    import snn_pkg::*;
#(
    parameter int DEPTH_F   = 5,
    parameter int DEPTH_I   = 25,
    parameter int WIDTH_W   = 8,
    parameter int WIDTH_PKT = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 f_wr_valid,
    output logic                                 f_wr_ready,
    input  logic [$clog2(DEPTH_F*DEPTH_F)-1:0]   f_wr_addr,
    input  logic [WIDTH_W-1:0]                   f_wr_data,
    input  logic                                 i_wr_valid,
    output logic                                 i_wr_ready,
    input  logic [$clog2(DEPTH_I*DEPTH_I)-1:0]   i_wr_addr,
    input  logic                                 i_wr_data,
    output logic                                 f_pkt_valid,
    input  logic                                 f_pkt_ready,
    output logic [WIDTH_PKT-1:0]                 f_pkt,
    output logic                                 i_pkt_valid,
    input  logic                                 i_pkt_ready,
    output logic [WIDTH_PKT-1:0]                 i_pkt
);

    localparam int F_N  = DEPTH_F * DEPTH_F;
    localparam int I_N  = DEPTH_I * DEPTH_I;
    localparam int F_AW = $clog2(F_N);
    localparam int I_AW = $clog2(I_N);
`ifdef SNN_MEM_TS_MARKER_EN
    localparam int I_NPKT = 2 * DEPTH_I + 1;
`else
    localparam int I_NPKT = 2 * DEPTH_I;
`endif
    localparam int F_IW = $clog2(F_N + 1);
    localparam int I_IW = $clog2(I_NPKT + 1);

    logic [F_N-1:0][WIDTH_W-1:0] r_fmem;
    logic [I_N-1:0]              r_imem;
    logic [4:0]                  r_ts;

    logic            w_f_in_range, w_f_store;
    logic            w_i_in_range, w_i_store;
    logic [F_IW-1:0] w_f_idx, w_f_row;
    logic [I_IW-1:0] w_i_idx;
    logic [I_IW-2:0] w_i_row_k;
    logic [I_AW-1:0] w_row_base;
    logic [DEPTH_I-1:0] w_row;
    logic            w_i_done;
    pkt_t            w_f_pkt, w_i_pkt;

    assign w_f_in_range = (f_wr_addr < F_AW'(F_N));
    assign w_i_in_range = (i_wr_addr < I_AW'(I_N));

    snn_pkt_src #(.N(F_N), .NPKT(F_N)) u_f_src (
        .clk(clk), .rst(rst),
        .i_wr_valid(f_wr_valid), .i_wr_in_range(w_f_in_range),
        .o_wr_ready(f_wr_ready), .o_wr_store(w_f_store),
        .i_pkt_ready(f_pkt_ready), .o_pkt_valid(f_pkt_valid), .o_idx(w_f_idx)
    );

    snn_pkt_src #(.N(I_N), .NPKT(I_NPKT)) u_i_src (
        .clk(clk), .rst(rst),
        .i_wr_valid(i_wr_valid), .i_wr_in_range(w_i_in_range),
        .o_wr_ready(i_wr_ready), .o_wr_store(w_i_store),
        .i_pkt_ready(i_pkt_ready), .o_pkt_valid(i_pkt_valid), .o_idx(w_i_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fmem <= '0;
            r_imem <= '0;
        end else begin
            if (w_f_store) r_fmem[f_wr_addr] <= f_wr_data;
            if (w_i_store) r_imem[i_wr_addr] <= i_wr_data;
        end
    end

    assign w_i_done = i_pkt_valid & i_pkt_ready & (w_i_idx == I_IW'(I_NPKT - 1));

    // Counts completed ifmap streams; 5 bits so it wraps at 32 timesteps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts <= '0;
        end else if (w_i_done) begin
            r_ts <= r_ts + 1'b1;
        end
    end

    assign w_f_row = w_f_idx / F_IW'(DEPTH_F);
    assign w_f_pkt = make_pkt(3'(w_f_row), DST_BCAST_Y, PKT_FILTER, 5'(w_f_idx),
                              PKT_DATA_W'(r_fmem[w_f_idx]));

    // Two packets per ifmap row: even index carries row[12:0], odd index row[24:13].
    assign w_i_row_k  = w_i_idx[I_IW-1:1];
    assign w_row_base = I_AW'(w_i_row_k) * I_AW'(DEPTH_I);
    assign w_row      = r_imem[w_row_base +: DEPTH_I];

    always_comb begin
        w_i_pkt = make_pkt(DST_BCAST_X, DST_BCAST_Y, PKT_IFMAP_LO, 5'(w_i_row_k),
                           {4'b0, w_row[12:0]});
        if (w_i_idx == I_IW'(2 * DEPTH_I)) begin
            w_i_pkt = make_pkt(DST_BCAST_X, DST_BCAST_Y, PKT_TS_END, r_ts, '0);
        end else if (w_i_idx[0]) begin
            w_i_pkt = make_pkt(DST_BCAST_X, DST_BCAST_Y, PKT_IFMAP_HI, 5'(w_i_row_k),
                               {5'b0, w_row[24:13]});
        end
    end

    assign f_pkt = w_f_pkt;
    assign i_pkt = w_i_pkt;

endmodule

// File: tb/tb_snn_input_mem.sv
// Directed, table-driven bench for snn_input_mem; expected packets are hand-computed.
module tb_snn_input_mem;

`ifdef SNN_MEM_TS_MARKER_EN
    localparam int I_NPKT = 51;
`else
    localparam int I_NPKT = 50;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        f_wr_valid, f_wr_ready;
    logic [4:0]  f_wr_addr;
    logic [7:0]  f_wr_data;
    logic        i_wr_valid, i_wr_ready;
    logic [9:0]  i_wr_addr;
    logic        i_wr_data;
    logic        f_pkt_valid, f_pkt_ready;
    logic [31:0] f_pkt;
    logic        i_pkt_valid, i_pkt_ready;
    logic [31:0] i_pkt;

    int checks = 0;
    int errors = 0;
    logic [31:0] f_got[$];
    logic [31:0] i_got[$];

    typedef struct {
        int          phase;
        bit          is_i;
        int          idx;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    snn_input_mem dut (
        .clk(clk), .rst(rst),
        .f_wr_valid(f_wr_valid), .f_wr_ready(f_wr_ready), .f_wr_addr(f_wr_addr), .f_wr_data(f_wr_data),
        .i_wr_valid(i_wr_valid), .i_wr_ready(i_wr_ready), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
        .f_pkt_valid(f_pkt_valid), .f_pkt_ready(f_pkt_ready), .f_pkt(f_pkt),
        .i_pkt_valid(i_pkt_valid), .i_pkt_ready(i_pkt_ready), .i_pkt(i_pkt)
    );

    always #5 clk = ~clk;

    // Handshakes are recorded on the falling edge; the transfer happens on the next rising edge.
    always @(negedge clk) begin
        if (f_pkt_valid && f_pkt_ready) f_got.push_back(f_pkt);
        if (i_pkt_valid && i_pkt_ready) i_got.push_back(i_pkt);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fexp(input int k);
        return {3'(k / 5), 5'h1F, 2'b00, 5'(k), 9'b0, 8'(k)};
    endfunction

    function automatic logic pat_bit(input int pat, input int a);
        case (pat)
            0:       return a < 25;
            1:       return a >= 600;
            default: return (a % 25) == 0;
        endcase
    endfunction

    task automatic add(input int ph, input bit is_i, input int idx, input logic [31:0] e);
        vecs.push_back('{ph, is_i, idx, e});
    endtask

    task automatic apply_table(input int ph);
        logic [31:0] act;
        for (int n = 0; n < vecs.size(); n++) begin
            if (vecs[n].phase == ph) begin
                act = 'x;
                if (vecs[n].is_i && vecs[n].idx < i_got.size()) act = i_got[vecs[n].idx];
                if (!vecs[n].is_i && vecs[n].idx < f_got.size()) act = f_got[vecs[n].idx];
                chk($sformatf("p%0d_%s_pkt%0d", ph, vecs[n].is_i ? "ifmap" : "filter", vecs[n].idx),
                    act, vecs[n].exp);
            end
        end
    endtask

    task automatic f_wr(input int a, input int d);
        f_wr_valid = 1'b1;
        f_wr_addr  = 5'(a);
        f_wr_data  = 8'(d);
        @(posedge clk); #1;
        f_wr_valid = 1'b0;
    endtask

    task automatic load_ifmap(input int pat);
        for (int a = 0; a < 625; a++) begin
            i_wr_valid = 1'b1;
            i_wr_addr  = 10'(a);
            i_wr_data  = pat_bit(pat, a);
            @(posedge clk); #1;
        end
        i_wr_valid = 1'b0;
    endtask

    task automatic wait_ifmap(input string name);
        for (int t = 0; t < 200; t++) begin
            if (i_got.size() >= I_NPKT) break;
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_count"}, 32'(i_got.size()), 32'(I_NPKT));
        chk({name, "_valid_low"}, 32'(i_pkt_valid), 32'd0);
        chk({name, "_wr_ready_back"}, 32'(i_wr_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        f_wr_valid = 1'b0; f_wr_addr = '0; f_wr_data = '0; f_pkt_ready = 1'b0;
        i_wr_valid = 1'b0; i_wr_addr = '0; i_wr_data = 1'b0; i_pkt_ready = 1'b0;

        add(1, 0, 0,  32'h1F00_0000);
        add(1, 0, 1,  32'h1F02_0001);
        add(1, 0, 5,  32'h3F0A_0005);
        add(1, 0, 24, 32'h9F30_0018);
        add(2, 0, 0,  32'h1F00_0000);
        add(2, 0, 24, 32'h9F30_0018);
        add(2, 1, 0,  32'hFF40_1FFF);
        add(2, 1, 1,  32'hFF80_0FFF);
        add(2, 1, 2,  32'hFF42_0000);
        add(2, 1, 49, 32'hFFB0_0000);
        add(3, 1, 0,  32'hFF40_0000);
        add(3, 1, 1,  32'hFF80_0000);
        add(3, 1, 48, 32'hFF70_1FFF);
        add(3, 1, 49, 32'hFFB0_0FFF);
        add(4, 1, 0,  32'hFF40_0001);
        add(4, 1, 1,  32'hFF80_0000);
        add(4, 1, 48, 32'hFF70_0001);
`ifdef SNN_MEM_TS_MARKER_EN
        add(2, 1, 50, 32'hFFC0_0000);
        add(3, 1, 50, 32'hFFC2_0000);
        add(4, 1, 50, 32'hFFC0_0000);
`endif

        #3;
        chk("rst_f_pkt_valid", 32'(f_pkt_valid), 32'd0);
        chk("rst_i_pkt_valid", 32'(i_pkt_valid), 32'd0);
        chk("rst_f_wr_ready", 32'(f_wr_ready), 32'd1);
        chk("rst_i_wr_ready", 32'(i_wr_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Filter load with a dropped out-of-range write, then a 10-cycle stall mid-stream.
        for (int k = 0; k < 24; k++) f_wr(k, k);
        f_wr(30, 99);
        chk("f_oob_not_counted_valid", 32'(f_pkt_valid), 32'd0);
        chk("f_oob_not_counted_ready", 32'(f_wr_ready), 32'd1);
        f_wr(24, 24);
        chk("f_first_valid", 32'(f_pkt_valid), 32'd1);
        chk("f_wr_ready_low", 32'(f_wr_ready), 32'd0);
        chk("f_first_pkt", f_pkt, 32'h1F00_0000);
        f_pkt_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        f_pkt_ready = 1'b0;
        for (int s = 0; s < 10; s++) begin
            chk($sformatf("f_stall_pkt_c%0d", s), {f_pkt[31:1], f_pkt_valid & f_pkt[0]}, fexp(10));
            @(posedge clk); #1;
        end
        chk("f_stall_count", 32'(f_got.size()), 32'd10);
        f_pkt_ready = 1'b1;
        for (int t = 0; t < 100 && f_got.size() < 25; t++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("f_count", 32'(f_got.size()), 32'd25);
        for (int k = 0; k < 25; k++)
            chk($sformatf("f_all_pkt%0d", k), (k < f_got.size()) ? f_got[k] : 'x, fexp(k));
        apply_table(1);
        chk("f_wr_ready_back", 32'(f_wr_ready), 32'd1);

        // Interleaved loads: filter writes every other cycle alongside a continuous ifmap load.
        f_got.delete();
        i_got.delete();
        i_pkt_ready = 1'b1;
        for (int c = 0; c < 625; c++) begin
            i_wr_valid = 1'b1;
            i_wr_addr  = 10'(c);
            i_wr_data  = pat_bit(0, c);
            f_wr_valid = (c < 50) && (c % 2 == 0);
            f_wr_addr  = 5'(c / 2);
            f_wr_data  = 8'(c / 2);
            @(posedge clk); #1;
        end
        i_wr_valid = 1'b0;
        f_wr_valid = 1'b0;
        chk("i_first_valid", 32'(i_pkt_valid), 32'd1);
        chk("i_wr_ready_low", 32'(i_wr_ready), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("i_wr_ready_low_mid", 32'(i_wr_ready), 32'd0);
        wait_ifmap("ts0");
        chk("p2_f_count", 32'(f_got.size()), 32'd25);
        apply_table(2);

        // Second timestep overwrites the ifmap with row 24 set.
        i_got.delete();
        load_ifmap(1);
        wait_ifmap("ts1");
        apply_table(3);

        // Reset while ifmap packet 20 is on the output, then a fresh load restreams from row 0.
        i_got.delete();
        load_ifmap(0);
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            if (i_got.size() >= 20) break;
        end
        #1;
        chk("pre_rst_pkt20", i_pkt, 32'hFF54_0000);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(i_pkt_valid), 32'd0);
        chk("rst_mid_wr_ready", 32'(i_wr_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_count", 32'(i_got.size()), 32'd20);
        i_got.delete();
        load_ifmap(2);
        wait_ifmap("restream");
        apply_table(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
